float_to_fix_pipe: RTL

//  Pipelined, parametrised IEEE-754-style float -> signed fixed-point converter with valid/ready flow control.

---
 rtl/float_to_fix_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/float_to_fix_pipe.sv
// float_to_fix_pipe: 3-stage float -> signed Q(W-FRAC).FRAC converter with RNE rounding, saturation and valid/ready flow
//  clk_i, rst_i                  : rising-edge clock, synchronous active-high reset
//  in_valid_i, in_ready_o, float_i : operand handshake, float_i = {sign, exp, mantissa}
//  out_valid_o, out_ready_i, fixed_o : result handshake, two's complement fixed-point result
//  ovf_o, udf_o, nan_o           : saturated (too large or Inf), non-zero rounded to 0, NaN input
module float_to_fix_pipe #(
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int FIXED_OP_WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]  float_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [FIXED_OP_WIDTH-1:0]     fixed_o,
  output logic                          ovf_o,
  output logic                          udf_o,
  output logic                          nan_o
);
  localparam int EW = EXP_WIDTH;
  localparam int MW = MAN_WIDTH;
  localparam int W = FIXED_OP_WIDTH;
  localparam int BIAS = 2 ** (EW - 1) - 1;
  localparam int KW = EW + $clog2(MW + FRAC_BITS + W + 4) + 2;
  localparam int SW = W + MW + 2;
  logic v1, v2, ld1, ld2, ld3;
  logic s1, inf1, nan1, s2, inf2, nan2, nz2, big2;
  logic [MW:0] sig1;
  logic signed [KW-1:0] k1;
  logic [W-1:0] mag2;
  assign ld3 = ~out_valid_o | out_ready_i;
  assign ld2 = ~v2 | ld3;
  assign ld1 = ~v1 | ld2;
  assign in_ready_o = ld1;
  logic [EW-1:0] e;
  logic [MW-1:0] m;
  logic e_max, e_zero;
  assign e = float_i[MW+:EW];
  assign m = float_i[MW-1:0];
  assign e_max = &e;
  assign e_zero = ~|e;
  always_ff @(posedge clk_i) begin
    if (rst_i) v1 <= 1'b0;
    else if (ld1) v1 <= in_valid_i;
    if (ld1) begin
      s1 <= float_i[EW+MW];
      inf1 <= e_max & ~|m;
      nan1 <= e_max & |m;
      sig1 <= {~e_zero, m};
      k1 <= KW'(e_zero ? EW'(1) : e) + KW'(FRAC_BITS) - KW'(BIAS + MW);
    end
  end
  logic neg, far;
  logic [KW-1:0] n;
  logic [SW-1:0] up_sh, dn;
  logic [2*MW+2:0] ext;
  logic [MW:0] q;
  logic g, st;
  // ext keeps MW+2 bits below the binary point so guard and sticky fall out of one shift
  always_comb begin
    neg = k1[KW-1];
    n = neg ? -k1 : k1;
    far = n > KW'(W + 1);
    up_sh = SW'(sig1) << n;
    ext = {sig1, {(MW+2){1'b0}}} >> n;
    q = ext[2*MW+2:MW+2];
    g = ext[MW+1];
    st = n > KW'(MW + 1) ? |sig1 : |ext[MW:0];
    dn = SW'(q) + SW'(g & (st | q[0]));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) v2 <= 1'b0;
    else if (ld2) v2 <= v1;
    if (ld2) begin
      s2 <= s1;
      inf2 <= inf1;
      nan2 <= nan1;
      nz2 <= |sig1;
      mag2 <= neg ? dn[W-1:0] : up_sh[W-1:0];
      big2 <= neg ? |dn[SW-1:W] : far ? |sig1 : |up_sh[SW-1:W];
    end
  end
  logic over;
  logic [W-1:0] lim, fix3;
  // a magnitude of exactly 2^(W-1) is representable only when negative
  always_comb begin
    over = inf2 | big2 | (s2 ? mag2[W-1] & |mag2[W-2:0] : mag2[W-1]);
    lim = s2 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    fix3 = nan2 ? '0 : over ? lim : s2 ? -mag2 : mag2;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      fixed_o <= '0;
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
      nan_o <= 1'b0;
    end else if (ld3) begin
      out_valid_o <= v2;
      fixed_o <= fix3;
      ovf_o <= over & ~nan2;
      udf_o <= ~nan2 & ~over & nz2 & ~|mag2;
      nan_o <= nan2;
    end
  end
endmodule
